cdc_fifo_flagged: RTL and testbench
===================================

CDC_FIFO_FLAGGED -- requirements
Module: cdc_fifo_flagged

Interface
REQ-001 Parameter WIDTH, default 36, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, entry count; SHALL be a power of two >=4; AW = log2(DEPTH).
REQ-003 Parameter SYNC_STAGES, default 2, flops per gray-pointer synchronizer (>=2).
REQ-004 Parameter AFULL_TH, default DEPTH-2; Parameter AEMPTY_TH, default 2.
REQ-005 Ports: w_clk in 1 write clock; w_rst in 1 write reset, synchronous, active-high; r_clk in 1 read clock; r_rst in 1 read reset, synchronous, active-high.
REQ-006 Write ports: w_en in 1 write request; data_in in WIDTH write data; full out 1; almost_full out 1; w_count out AW+1 write-side fill level; overflow out 1 rejected-write pulse.
REQ-007 Read ports: r_en in 1 read request; data_out out WIDTH read data; empty out 1; almost_empty out 1; r_count out AW+1 read-side fill level; underflow out 1 rejected-read pulse.

Function
REQ-008 Pointers SHALL be AW+1 bits, held in binary and registered gray form; only registered gray values cross domains, through SYNC_STAGES flops each way.
REQ-009 A write SHALL occur on w_clk edge when w_en=1 and full=0; data_in stored at wptr[AW-1:0], wptr increments, wrapping mod 2*DEPTH.
REQ-010 w_en=1 with full=1 SHALL drop the write, leave pointers and storage unchanged, and assert overflow for exactly that one w_clk cycle.
REQ-011 full SHALL be registered, asserting the cycle after the write filling entry DEPTH (next-gray equals synced rgray with top two bits inverted).
REQ-012 w_count SHALL equal wptr minus binary(synced rptr) mod 2*DEPTH, registered; range 0..DEPTH; almost_full = (w_count >= AFULL_TH).
REQ-013 empty SHALL be registered; r_count = binary(synced wptr) minus rptr mod 2*DEPTH; almost_empty = (r_count <= AEMPTY_TH).
REQ-014 r_en=1 with empty=1 SHALL be ignored, and underflow SHALL pulse for exactly that one r_clk cycle.
REQ-015 Flags SHALL be pessimistic: full/empty may deassert late by synchronizer latency, never assert late; no entry SHALL be overwritten unread or read twice.
REQ-016 Write-to-empty-deassert latency SHALL be SYNC_STAGES+2 r_clk edges max (non-FWFT), +1 in FWFT mode.
REQ-017 Simultaneous read and write SHALL both complete in their domains; single-entry FIFO with concurrent read/write SHALL not lose data.
REQ-018 Storage SHALL be an unreset register array, written only in w_clk domain.

Reset
REQ-019 w_rst SHALL clear wptr, wgray, read-pointer sync flops, w_count, overflow; full=0, almost_full=(0>=AFULL_TH).
REQ-020 r_rst SHALL clear rptr, rgray, write-pointer sync flops, r_count, underflow, data_out=0; empty=1, almost_empty=1.
REQ-021 Both resets SHALL be asserted together for >= SYNC_STAGES+1 cycles of the slower clock; one-sided reset mid-operation is unsupported and flagged by assertion in simulation.

Configuration
REQ-022 Macro CDC_FIFO_FWFT_EN, when defined, SHALL select first-word-fall-through: data_out shows the head word whenever empty=0; r_en with empty=0 pops it, next word (or empty=1) presented next r_clk cycle.
REQ-023 Without CDC_FIFO_FWFT_EN, data_out SHALL update on the r_clk edge with r_en=1 and empty=0 (one-cycle read latency) and hold otherwise.
REQ-024 In FWFT mode r_count SHALL include the word held in the output register.

Verification
REQ-025 Reset both, DEPTH=16: expect empty=1, full=0, w_count=0, r_count=0, data_out=0, almost_empty=1.
REQ-026 w_clk 100 MHz, r_clk 33 MHz, write 16 words 0x0..0xF, no reads: full=1 after 16th write; 17th write -> overflow pulse 1 cycle, w_count=16; then read 16 -> data 0x0..0xF in order, empty=1.
REQ-027 Read with empty=1 -> underflow one cycle, data_out unchanged, r_count=0.
REQ-028 Single write 0xABC to empty FIFO: empty deasserts within SYNC_STAGES+2 r_clk edges; non-FWFT read returns 0xABC next edge; FWFT shows 0xABC with r_en=0.
REQ-029 Continuous random w_en/r_en, unrelated clocks, 10k words: scoreboard exact order, zero loss/dup, pointers wrap >=300 times, no overflow/underflow when flags obeyed.
REQ-030 Fill to 14 (AFULL_TH=14): almost_full=1 at w_count=14; drain to 2: almost_empty=1 at r_count=2.

Source files
------------

// File: rtl/cdc_fifo_flagged.sv
// rtl/cdc_fifo_flagged.sv - dual-clock FIFO with gray-pointer sync, fill levels and error pulses
// Define CDC_FIFO_FWFT_EN for first-word-fall-through reads; default is one-cycle-latency reads.
module cdc_fifo_flagged #(
  parameter int WIDTH       = 36,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = DEPTH - 2,
  parameter int AEMPTY_TH   = 2,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             w_en,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             almost_full,
  output logic [AW:0]      w_count,
  output logic             overflow,
  input  logic             r_clk,
  input  logic             r_rst,
  input  logic             r_en,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             almost_empty,
  output logic [AW:0]      r_count,
  output logic             underflow
);

  localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_TH);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [AW:0] wbin, wgray, wbin_next, wgray_next, rsync_g, rsync_bin;
  logic [AW:0] rgray_sync [SYNC_STAGES];
  logic [AW:0] rgray;
  logic        w_do;

  assign w_do       = w_en & ~full;
  assign wbin_next  = wbin + {{AW{1'b0}}, w_do};
  assign wgray_next = bin2gray(wbin_next);
  assign rsync_g    = rgray_sync[SYNC_STAGES-1];
  assign rsync_bin  = gray2bin(rsync_g);
  assign almost_full = (w_count >= AFULL_LVL);

  always_ff @(posedge w_clk) begin
    if (w_do) mem[wbin[AW-1:0]] <= data_in;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) rgray_sync[i] <= '0;
    end else begin
      rgray_sync[0] <= rgray;
      for (int i = 1; i < SYNC_STAGES; i++) rgray_sync[i] <= rgray_sync[i-1];
    end
  end

  // Full when the next write pointer laps the synced read pointer by exactly DEPTH.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      wbin     <= '0;
      wgray    <= '0;
      full     <= 1'b0;
      w_count  <= '0;
      overflow <= 1'b0;
    end else begin
      wbin     <= wbin_next;
      wgray    <= wgray_next;
      full     <= (wgray_next == {~rsync_g[AW:AW-1], rsync_g[AW-2:0]});
      w_count  <= wbin_next - rsync_bin;
      overflow <= w_en & full;
    end
  end

  // ---------------- read domain ----------------
  logic [AW:0] rbin, rbin_next, rgray_next, wsync_g, wsync_bin;
  logic [AW:0] wgray_sync [SYNC_STAGES];
  logic        r_pop;

  assign rbin_next  = rbin + {{AW{1'b0}}, r_pop};
  assign rgray_next = bin2gray(rbin_next);
  assign wsync_g    = wgray_sync[SYNC_STAGES-1];
  assign wsync_bin  = gray2bin(wsync_g);
  assign almost_empty = (r_count <= AEMPTY_LVL);

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) wgray_sync[i] <= '0;
    end else begin
      wgray_sync[0] <= wgray;
      for (int i = 1; i < SYNC_STAGES; i++) wgray_sync[i] <= wgray_sync[i-1];
    end
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      rbin      <= '0;
      rgray     <= '0;
      underflow <= 1'b0;
    end else begin
      rbin      <= rbin_next;
      rgray     <= rgray_next;
      underflow <= r_en & empty;
    end
  end

`ifdef CDC_FIFO_FWFT_EN
  // Output register holds the head word; memory is pulled whenever that slot is free or being popped.
  logic mem_empty, out_valid, out_valid_next;

  assign r_pop          = ~mem_empty & (~out_valid | r_en);
  assign out_valid_next = r_pop | (out_valid & ~r_en);
  assign empty          = ~out_valid;

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      mem_empty <= 1'b1;
      out_valid <= 1'b0;
      data_out  <= '0;
      r_count   <= '0;
    end else begin
      mem_empty <= (rgray_next == wsync_g);
      out_valid <= out_valid_next;
      if (r_pop) data_out <= mem[rbin[AW-1:0]];
      r_count   <= wsync_bin - rbin_next + {{AW{1'b0}}, out_valid_next};
    end
  end
`else
  assign r_pop = r_en & ~empty;

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      empty    <= 1'b1;
      data_out <= '0;
      r_count  <= '0;
    end else begin
      empty   <= (rgray_next == wsync_g);
      if (r_pop) data_out <= mem[rbin[AW-1:0]];
      r_count <= wsync_bin - rbin_next;
    end
  end
`endif

  // Resets must rise together; a one-sided reset would leave stale pointers in the other domain.
  logic w_rst_q, r_rst_q;

  always_ff @(posedge w_clk) begin
    w_rst_q <= w_rst;
    if (w_rst && !w_rst_q) assert (r_rst);
  end

  always_ff @(posedge r_clk) begin
    r_rst_q <= r_rst;
    if (r_rst && !r_rst_q) assert (w_rst);
  end

endmodule

// File: tb/tb_cdc_fifo_flagged.sv
// tb/tb_cdc_fifo_flagged.sv - scoreboard bench for cdc_fifo_flagged (honours CDC_FIFO_FWFT_EN)
module tb_cdc_fifo_flagged;

  logic        w_clk = 1'b0, r_clk = 1'b0;
  logic        w_rst = 1'b1, r_rst = 1'b1;
  logic        w_en = 1'b0, r_en = 1'b0;
  logic [35:0] data_in = '0;
  logic [35:0] data_out;
  logic        full, almost_full, overflow, empty, almost_empty, underflow;
  logic [4:0]  w_count, r_count;

  int          checks = 0;
  int          errors = 0;
  logic [35:0] exp_q[$];

`ifdef CDC_FIFO_FWFT_EN
  localparam int LAT_MAX = 5;
`else
  localparam int LAT_MAX = 4;
`endif

  cdc_fifo_flagged dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_en(w_en), .data_in(data_in),
    .full(full), .almost_full(almost_full), .w_count(w_count), .overflow(overflow),
    .r_clk(r_clk), .r_rst(r_rst), .r_en(r_en), .data_out(data_out),
    .empty(empty), .almost_empty(almost_empty), .r_count(r_count), .underflow(underflow)
  );

  always #50 w_clk = ~w_clk;
  always #151 r_clk = ~r_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected word whenever the DUT presents a read result.
  initial begin : monitor
    logic [35:0] e;
`ifndef CDC_FIFO_FWFT_EN
    logic pend;
    pend = 1'b0;
`endif
    forever begin
      @(negedge r_clk);
`ifdef CDC_FIFO_FWFT_EN
      if (r_en && !empty) begin
`else
      if (pend) begin
`endif
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got 0x%0h expected no word", data_out);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", 64'(data_out), 64'(e));
        end
      end
`ifndef CDC_FIFO_FWFT_EN
      pend = r_en & ~empty;
`endif
    end
  end

  initial begin : watchdog
    #12000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : main
    int lat, wn, rd, ovf_seen, unf_seen, wcyc, rcyc;

    repeat (5) @(posedge r_clk);
    #1;
    w_rst = 1'b0;
    r_rst = 1'b0;
    repeat (2) @(posedge r_clk);
    #1;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_r_count", 64'(r_count), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_almost_empty", 64'(almost_empty), 64'd1);
    check("rst_underflow", 64'(underflow), 64'd0);
    @(negedge w_clk);
    check("rst_full", 64'(full), 64'd0);
    check("rst_w_count", 64'(w_count), 64'd0);
    check("rst_almost_full", 64'(almost_full), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);

    // Fill 16 words with no reads; almost_full expected from w_count 14 upward.
    for (int i = 0; i < 16; i++) begin
      @(negedge w_clk);
      check("fill_w_count", 64'(w_count), 64'(i));
      check("fill_almost_full", 64'(almost_full), 64'(i >= 14));
      check("fill_full", 64'(full), 64'd0);
      w_en = 1'b1;
      data_in = 36'(i);
      exp_q.push_back(36'(i));
    end
    @(negedge w_clk);
    check("full_after16", 64'(full), 64'd1);
    check("w_count16", 64'(w_count), 64'd16);
    check("almost_full16", 64'(almost_full), 64'd1);
    data_in = 36'h10;
    @(negedge w_clk);
    w_en = 1'b0;
    check("overflow_pulse", 64'(overflow), 64'd1);
    check("w_count_ovf", 64'(w_count), 64'd16);
    check("full_ovf", 64'(full), 64'd1);
    @(negedge w_clk);
    check("overflow_clear", 64'(overflow), 64'd0);

    repeat (6) @(posedge r_clk);
    #1;
    check("r_count16", 64'(r_count), 64'd16);
    check("empty_full", 64'(empty), 64'd0);
    check("almost_empty16", 64'(almost_empty), 64'd0);
    for (int k = 0; k < 16; k++) begin
      @(posedge r_clk);
      #1;
      check("drain_r_count", 64'(r_count), 64'(16 - k));
      check("drain_almost_empty", 64'(almost_empty), 64'((16 - k) <= 2));
      check("drain_empty", 64'(empty), 64'd0);
      r_en = 1'b1;
    end
    @(posedge r_clk);
    #1;
    r_en = 1'b0;
    check("drained_empty", 64'(empty), 64'd1);
    check("drained_r_count", 64'(r_count), 64'd0);
    check("drained_almost_empty", 64'(almost_empty), 64'd1);

    @(posedge r_clk);
    #1;
    r_en = 1'b1;
    @(posedge r_clk);
    #1;
    r_en = 1'b0;
    check("underflow_pulse", 64'(underflow), 64'd1);
    check("underflow_data_hold", 64'(data_out), 64'hF);
    check("underflow_r_count", 64'(r_count), 64'd0);
    @(posedge r_clk);
    #1;
    check("underflow_clear", 64'(underflow), 64'd0);

    // Single word into an empty FIFO: measure empty-deassert latency in r_clk edges.
    @(negedge w_clk);
    w_en = 1'b1;
    data_in = 36'hABC;
    exp_q.push_back(36'hABC);
    @(posedge w_clk);
    #1;
    w_en = 1'b0;
    lat = 0;
    do begin
      @(posedge r_clk);
      #1;
      lat++;
    end while (empty && lat < 10);
    check("abc_latency_ok", 64'(lat <= LAT_MAX), 64'd1);
`ifdef CDC_FIFO_FWFT_EN
    check("abc_fwft_show", 64'(data_out), 64'hABC);
    r_en = 1'b1;
    @(posedge r_clk);
    #1;
    r_en = 1'b0;
    check("abc_fwft_empty", 64'(empty), 64'd1);
`else
    r_en = 1'b1;
    @(posedge r_clk);
    #1;
    r_en = 1'b0;
    check("abc_read", 64'(data_out), 64'hABC);
    check("abc_empty", 64'(empty), 64'd1);
`endif

    // Random traffic obeying the flags on both sides.
    ovf_seen = 0;
    unf_seen = 0;
    wn = 0;
    rd = 0;
    fork
      begin
        wcyc = 0;
        while (wn < 10000 && wcyc < 60000) begin
          @(negedge w_clk);
          wcyc++;
          ovf_seen += int'(overflow);
          if (!full && $urandom_range(1) == 1) begin
            w_en = 1'b1;
            data_in = 36'(wn) ^ 36'h9_A5A5_0000;
            exp_q.push_back(36'(wn) ^ 36'h9_A5A5_0000);
            wn++;
          end else begin
            w_en = 1'b0;
          end
        end
        @(negedge w_clk);
        w_en = 1'b0;
      end
      begin
        rcyc = 0;
        while (rd < 10000 && rcyc < 20000) begin
          @(posedge r_clk);
          #1;
          rcyc++;
          unf_seen += int'(underflow);
          if (!empty && $urandom_range(9) != 0) begin
            r_en = 1'b1;
            rd++;
          end else begin
            r_en = 1'b0;
          end
        end
        @(posedge r_clk);
        #1;
        r_en = 1'b0;
      end
    join
    check("rand_writes", 64'(wn), 64'd10000);
    check("rand_reads", 64'(rd), 64'd10000);
    check("rand_no_overflow", 64'(ovf_seen), 64'd0);
    check("rand_no_underflow", 64'(unf_seen), 64'd0);

    repeat (4) @(posedge r_clk);
    #1;
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    check("final_empty", 64'(empty), 64'd1);
    check("final_r_count", 64'(r_count), 64'd0);
    @(negedge w_clk);
    check("final_full", 64'(full), 64'd0);
    check("final_w_count", 64'(w_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
